// File: rtl/time_keeper_pkg.sv
// Shared types and constants for the time_keeper clock/alarm block.
package time_keeper_pkg;

  localparam int unsigned MAX_HOUR    = 23;
  localparam int unsigned MAX_MIN_SEC = 59;
  localparam int unsigned HOUR_W      = 5;
  localparam int unsigned MIN_SEC_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_e;

endpackage

// File: rtl/mod_counter.sv
// Binary modulo-N increment stage; carry_c marks the wrap so stages can chain.
module mod_counter #(
  parameter int unsigned W = 6
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] modulus,
  input  logic         inc,
  output logic [W-1:0] next_c,
  output logic         carry_c
);

  assign carry_c = inc && (value == W'(modulus - W'(1)));
  assign next_c  = carry_c ? '0 : W'(value + W'(inc));

endmodule

// File: rtl/time_keeper.sv
// Time-of-day counter with range-checked loads and an alarm with ring/snooze timing.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned RING_SEC   = 60
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 run,
  input  logic                 set_valid,
  input  logic [HOUR_W-1:0]    set_hour,
  input  logic [MIN_SEC_W-1:0] set_min,
  input  logic [MIN_SEC_W-1:0] set_sec,
  output logic                 set_ready,
  input  logic                 alarm_wr,
  input  logic [HOUR_W-1:0]    alarm_hour,
  input  logic [MIN_SEC_W-1:0] alarm_min,
  input  logic                 alarm_en,
  input  logic                 snooze,
  input  logic                 dismiss,
  output logic [HOUR_W-1:0]    hour,
  output logic [MIN_SEC_W-1:0] min,
  output logic [MIN_SEC_W-1:0] sec,
  output logic                 alarm_ring,
  output logic                 set_err
);

  localparam int unsigned CNT_MAX = (SNOOZE_SEC > RING_SEC) ? SNOOZE_SEC : RING_SEC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  logic [HOUR_W-1:0]    al_hour;
  logic [MIN_SEC_W-1:0] al_min;
  logic [HOUR_W-1:0]    hour_n;
  logic [MIN_SEC_W-1:0] min_n, sec_n;
  logic                 sec_c, min_c, day_c;
  logic                 set_fire, set_ok, alarm_ok, adv, hour_hit, trig;
  state_e               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;

  assign set_fire = set_valid && set_ready;
  assign set_ok   = (set_hour <= HOUR_W'(MAX_HOUR)) && (set_min <= MIN_SEC_W'(MAX_MIN_SEC)) &&
                    (set_sec <= MIN_SEC_W'(MAX_MIN_SEC));
  assign alarm_ok = (alarm_hour <= HOUR_W'(MAX_HOUR)) && (alarm_min <= MIN_SEC_W'(MAX_MIN_SEC));
  // A load handshake owns the time registers, so a coincident tick is dropped.
  assign adv      = tick && run && !set_fire;

  mod_counter #(.W(MIN_SEC_W)) u_sec (
    .value(sec), .modulus(MIN_SEC_W'(MAX_MIN_SEC + 1)), .inc(adv),
    .next_c(sec_n), .carry_c(sec_c)
  );
  mod_counter #(.W(MIN_SEC_W)) u_min (
    .value(min), .modulus(MIN_SEC_W'(MAX_MIN_SEC + 1)), .inc(sec_c),
    .next_c(min_n), .carry_c(min_c)
  );
  mod_counter #(.W(HOUR_W)) u_hour (
    .value(hour), .modulus(HOUR_W'(MAX_HOUR + 1)), .inc(min_c),
    .next_c(hour_n), .carry_c(day_c)
  );

  // Alarm fires only when an advance lands on hh:mm:00; a direct load never matches here.
  assign hour_hit = day_c ? (al_hour == '0) : (hour_n == al_hour);
  assign trig     = alarm_en && sec_c && (min_n == al_min) && hour_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hour <= '0;
      min  <= '0;
      sec  <= '0;
    end else if (set_fire && set_ok) begin
      hour <= set_hour;
      min  <= set_min;
      sec  <= set_sec;
    end else begin
      hour <= hour_n;
      min  <= min_n;
      sec  <= sec_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      al_hour   <= '0;
      al_min    <= '0;
      set_err   <= 1'b0;
      set_ready <= 1'b1;
    end else begin
      if (alarm_wr && alarm_ok) begin
        al_hour <= alarm_hour;
        al_min  <= alarm_min;
      end
      set_err   <= (set_fire && !set_ok) || (alarm_wr && !alarm_ok);
      set_ready <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      alarm_ring <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      alarm_ring <= (state_nxt == ST_RING);
    end
  end

  // Ring/snooze countdown runs on every tick, independent of run.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (trig) begin
          state_nxt = ST_RING;
          cnt_nxt   = CW'(RING_SEC);
        end
      end
      ST_RING: begin
        if (dismiss || !alarm_en) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (snooze) begin
          state_nxt = ST_SNOOZE;
          cnt_nxt   = CW'(SNOOZE_SEC);
        end else if (tick) begin
          if (cnt <= CW'(1)) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
      end
      ST_SNOOZE: begin
        if (dismiss || !alarm_en) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (tick) begin
          if (cnt <= CW'(1)) begin
            state_nxt = ST_RING;
            cnt_nxt   = CW'(RING_SEC);
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule
